// File: rtl/alsu_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// alsu_cmd_driver_if
// Bundles every non-clock signal of alsu_cmd_driver.
//   command stream : cmd_valid, cmd_ready, cmd_data[15:0]
//   ALSU pins      : alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
//                    alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
//                    alsu_bypass_B, alsu_direction (driven by the driver)
//                    alsu_out[5:0], alsu_leds[15:0] (returned by the ALSU)
//   response stream: rsp_valid, rsp_ready, rsp_out, rsp_leds, rsp_opcode,
//                    rsp_invalid
//   status         : invalid_count[7:0], busy
// Modport slave is the driver's view; master is the environment's view
// (command source, ALSU and response sink).
// ---------------------------------------------------------------------------
interface alsu_cmd_driver_if;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_data;

    logic [2:0]        alsu_opcode;
    logic signed [2:0] alsu_A;
    logic signed [2:0] alsu_B;
    logic              alsu_cin;
    logic              alsu_serial_in;
    logic              alsu_red_op_A;
    logic              alsu_red_op_B;
    logic              alsu_bypass_A;
    logic              alsu_bypass_B;
    logic              alsu_direction;
    logic signed [5:0] alsu_out;
    logic [15:0]       alsu_leds;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [5:0]        rsp_out;
    logic [15:0]       rsp_leds;
    logic [2:0]        rsp_opcode;
    logic              rsp_invalid;

    logic [7:0]        invalid_count;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_data, alsu_out, alsu_leds, rsp_ready,
        output cmd_ready, alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
               alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
               alsu_direction, rsp_valid, rsp_out, rsp_leds, rsp_opcode,
               rsp_invalid, invalid_count, busy
    );

    modport master (
        output cmd_valid, cmd_data, alsu_out, alsu_leds, rsp_ready,
        input  cmd_ready, alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
               alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
               alsu_direction, rsp_valid, rsp_out, rsp_leds, rsp_opcode,
               rsp_invalid, invalid_count, busy
    );
endinterface

// File: rtl/alsu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alsu_cmd_driver
// Queues 16-bit ALSU commands, drives them onto registered ALSU pins one per
// cycle, tracks each issued command with an opcode/invalid tag and captures
// the ALSU result into an in-order response FIFO.
// Ports:
//   clk  - sole clock, everything on posedge
//   rst  - synchronous active-high reset
//   bus  - alsu_cmd_driver_if.slave (command, ALSU pins, response, status)
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high; valid never depends on ready, and the payload is held stable while
// valid is high and ready is low.
// ---------------------------------------------------------------------------
module alsu_cmd_driver #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int LATENCY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    alsu_cmd_driver_if.slave bus
);
    localparam int                 CAW       = $clog2(CMD_DEPTH);
    localparam int                 RAW       = $clog2(RSP_DEPTH);
    localparam int                 RSP_W     = 26;
    localparam logic [CAW:0]       CMD_FULL  = CMD_DEPTH[CAW:0];
    localparam logic [RAW+1:0]     RSP_LIMIT = RSP_DEPTH[RAW+1:0];

    // command FIFO
    logic [15:0]      cmd_mem_q [CMD_DEPTH];
    logic [CAW-1:0]   cmd_wr_q, cmd_rd_q;
    logic [CAW:0]     cmd_cnt_q, cmd_cnt_d;
    logic             cmd_full, cmd_empty, cmd_push;
    logic [15:0]      head;
    logic [2:0]       head_op;
    logic             head_inv;

    // issue / tag pipeline
    logic             issue, capture;
    logic [15:0]      pins_q;
    logic [LATENCY:0] tag_vld_q, tag_inv_q;
    logic [2:0]       tag_op_q [LATENCY+1];
    logic [RAW:0]     inflight_q, inflight_d;
    logic [RAW+1:0]   credit_used;
    logic [7:0]       inv_cnt_q, inv_cnt_d;

    // response FIFO
    logic [RSP_W-1:0] rsp_mem_q [RSP_DEPTH];
    logic [RAW-1:0]   rsp_wr_q, rsp_rd_q;
    logic [RAW:0]     rsp_cnt_q, rsp_cnt_d;
    logic             rsp_pop;

    assign cmd_full      = (cmd_cnt_q == CMD_FULL);
    assign cmd_empty     = (cmd_cnt_q == '0);
    assign bus.cmd_ready = !rst && !cmd_full;
    assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
    assign head          = cmd_mem_q[cmd_rd_q];
    assign head_op       = head[15:13];
    assign head_inv      = (head_op == 3'd6) || (head_op == 3'd7) ||
                           ((head[4] || head[3]) && (head_op > 3'd1));

    assign rsp_pop = (rsp_cnt_q != '0) && bus.rsp_ready;

    // Every issued command owns a response slot until it is popped. A slot
    // being popped this cycle is already free before any new issue can reach
    // capture, so it is not counted; that keeps one issue per cycle going
    // while the consumer keeps up, and a capture never finds the FIFO full.
    assign credit_used = {1'b0, inflight_q} + {1'b0, rsp_cnt_q}
                       - {{(RAW + 1){1'b0}}, rsp_pop};
    assign issue       = !cmd_empty && (credit_used < RSP_LIMIT);
    assign capture     = tag_vld_q[LATENCY];

    always_comb begin
        cmd_cnt_d  = cmd_cnt_q;
        inflight_d = inflight_q;
        rsp_cnt_d  = rsp_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        if (cmd_push && !issue)      cmd_cnt_d = cmd_cnt_q + 1'b1;
        else if (!cmd_push && issue) cmd_cnt_d = cmd_cnt_q - 1'b1;
        if (issue && !capture)       inflight_d = inflight_q + 1'b1;
        else if (!issue && capture)  inflight_d = inflight_q - 1'b1;
        if (capture && !rsp_pop)     rsp_cnt_d = rsp_cnt_q + 1'b1;
        else if (!capture && rsp_pop) rsp_cnt_d = rsp_cnt_q - 1'b1;
        if (issue && head_inv && (inv_cnt_q != 8'hFF)) inv_cnt_d = inv_cnt_q + 1'b1;
    end

    // Storage arrays need no reset: the counters say what is valid.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q] <= bus.cmd_data;
        if (capture)  rsp_mem_q[rsp_wr_q] <= {bus.alsu_out, bus.alsu_leds,
                                              tag_op_q[LATENCY], tag_inv_q[LATENCY]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr_q   <= '0;
            cmd_rd_q   <= '0;
            cmd_cnt_q  <= '0;
            rsp_wr_q   <= '0;
            rsp_rd_q   <= '0;
            rsp_cnt_q  <= '0;
            inflight_q <= '0;
            inv_cnt_q  <= '0;
            pins_q     <= '0;
            tag_vld_q  <= '0;
            tag_inv_q  <= '0;
            for (int i = 0; i <= LATENCY; i++) tag_op_q[i] <= '0;
        end else begin
            if (cmd_push) cmd_wr_q <= cmd_wr_q + 1'b1;
            if (issue)    cmd_rd_q <= cmd_rd_q + 1'b1;
            if (capture)  rsp_wr_q <= rsp_wr_q + 1'b1;
            if (rsp_pop)  rsp_rd_q <= rsp_rd_q + 1'b1;
            cmd_cnt_q  <= cmd_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            inflight_q <= inflight_d;
            inv_cnt_q  <= inv_cnt_d;
            // Pins carry the head for exactly the cycle after issue, else 0.
            pins_q       <= issue ? head : 16'd0;
            tag_vld_q[0] <= issue;
            tag_inv_q[0] <= issue && head_inv;
            tag_op_q[0]  <= issue ? head_op : 3'd0;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_inv_q[i] <= tag_inv_q[i-1];
                tag_op_q[i]  <= tag_op_q[i-1];
            end
        end
    end

    assign bus.alsu_opcode    = pins_q[15:13];
    assign bus.alsu_A         = pins_q[12:10];
    assign bus.alsu_B         = pins_q[9:7];
    assign bus.alsu_cin       = pins_q[6];
    assign bus.alsu_serial_in = pins_q[5];
    assign bus.alsu_red_op_A  = pins_q[4];
    assign bus.alsu_red_op_B  = pins_q[3];
    assign bus.alsu_bypass_A  = pins_q[2];
    assign bus.alsu_bypass_B  = pins_q[1];
    assign bus.alsu_direction = pins_q[0];

    assign bus.rsp_valid = (rsp_cnt_q != '0);
    assign {bus.rsp_out, bus.rsp_leds, bus.rsp_opcode, bus.rsp_invalid} = rsp_mem_q[rsp_rd_q];

    assign bus.invalid_count = inv_cnt_q;
    assign bus.busy          = (cmd_cnt_q != '0) || (inflight_q != '0) || (rsp_cnt_q != '0);
endmodule
